anb_wr_arbiter_m: RTL and testbench

//  Round-robin arbiter that shares one ANB write path (address + data channel) among N requesters.
//  - Sits upstream of the ANB write register-slice stage; drives its m_a / m_d side.
//  - Grants one requester per burst: forwards its address beat, then exactly len+1 data beats.
//  - Re-arbitrates only after the final data beat is accepted.
//

---
 rtl/anb_wr_arbiter_m_if.sv | 44 ++++
 rtl/anb_wr_arbiter_m.sv | 158 +++++++++++++++
 tb/tb_anb_wr_arbiter_m.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/anb_wr_arbiter_m_if.sv
// ANB write-path bundle: N requester ports on the m_ side,
// one shared address+data path on the s_ side.
interface anb_wr_arbiter_m_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 64
);
  logic [N-1:0]        m_avalid;
  logic [N-1:0]        m_aready;
  logic [N*ADDR_W-1:0] m_addr;
  logic [N*LEN_W-1:0]  m_len;
  logic [N-1:0]        m_valid;
  logic [N-1:0]        m_ready;
  logic [N*DATA_W-1:0] m_data;
  logic [N-1:0]        m_last;

  logic              s_avalid;
  logic              s_aready;
  logic [ADDR_W-1:0] s_addr;
  logic [LEN_W-1:0]  s_len;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (
    input  m_avalid, m_addr, m_len,
    input  m_valid, m_data, m_last,
    input  s_aready, s_ready,
    output m_aready, m_ready,
    output s_avalid, s_addr, s_len,
    output s_valid, s_data, s_last
  );

  modport slave (
    output m_avalid, m_addr, m_len,
    output m_valid, m_data, m_last,
    output s_aready, s_ready,
    input  m_aready, m_ready,
    input  s_avalid, s_addr, s_len,
    input  s_valid, s_data, s_last
  );
endinterface

// File: rtl/anb_wr_arbiter_m.sv
// Round-robin arbiter sharing one ANB write path among N
// requesters; one burst in flight, re-arbitrated after last beat.
module anb_wr_arbiter_m #(
  parameter int N      = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  anb_wr_arbiter_m_if.master bus,
  output logic [N-1:0] gnt,
  output logic         err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              err_q, err_d;

  logic [PW-1:0]     gidx;
  logic [PW-1:0]     idx;
  logic [N-1:0]      pick;
  logic              av_g;
  logic              v_g;
  logic              last_g;
  logic [ADDR_W-1:0] addr_g;
  logic [LEN_W-1:0]  len_g;
  logic [DATA_W-1:0] data_g;
  logic              cnt_z;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] base,
    input int unsigned   k
  );
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(k);
    if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
    return s[PW-1:0];
  endfunction

  // one-hot grant drives an OR-mux; no index arithmetic on buses
  always_comb begin
    gidx   = '0;
    addr_g = '0;
    len_g  = '0;
    data_g = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        gidx   = PW'(i);
        addr_g = addr_g | bus.m_addr[i*ADDR_W +: ADDR_W];
        len_g  = len_g  | bus.m_len[i*LEN_W +: LEN_W];
        data_g = data_g | bus.m_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign av_g   = |(bus.m_avalid & gnt_q);
  assign v_g    = |(bus.m_valid & gnt_q);
  assign last_g = |(bus.m_last & gnt_q);
  assign cnt_z  = (cnt_q == '0);

  // lowest index at or above rr_q wins, wrapping at N
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = wrap(rr_q, k);
      if (bus.m_avalid[idx]) pick = ONE << idx;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    err_d   = 1'b0;

    bus.m_aready = '0;
    bus.m_ready  = '0;
    bus.s_avalid = 1'b0;
    bus.s_addr   = '0;
    bus.s_len    = '0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.m_avalid) begin
          gnt_d   = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.s_avalid = av_g;
        bus.s_addr   = addr_g;
        bus.s_len    = len_g;
        bus.m_aready = gnt_q & {N{bus.s_aready}};
        if (av_g && bus.s_aready) begin
          cnt_d   = len_g;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.s_valid = v_g;
        bus.s_data  = data_g;
        bus.s_last  = cnt_z;
        bus.m_ready = gnt_q & {N{bus.s_ready}};
        if (v_g && bus.s_ready) begin
          err_d = (last_g != cnt_z);
          if (cnt_z) begin
            rr_d    = wrap(gidx, 1);
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign gnt = gnt_q;
  assign err = err_q;

endmodule

// File: tb/tb_anb_wr_arbiter_m.sv
// Directed bench for anb_wr_arbiter_m: grants, bursts,
// backpressure, last mismatch, async reset, max length.
module tb_anb_wr_arbiter_m;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] gnt;
  logic         err;
  int checks = 0;
  int errors = 0;

  anb_wr_arbiter_m_if #(
    .N(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)
  ) bus ();

  anb_wr_arbiter_m #(
    .N(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .gnt (gnt),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.m_avalid = '0;
    bus.m_addr   = '0;
    bus.m_len    = '0;
    bus.m_valid  = '0;
    bus.m_data   = '0;
    bus.m_last   = '0;
    bus.s_aready = 1'b0;
    bus.s_ready  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // full-ready burst from IDLE with per-beat checks
  task automatic burst(
    input int          r,
    input logic [31:0] a,
    input int          len,
    input logic [63:0] base
  );
    bus.s_aready = 1'b1;
    bus.s_ready  = 1'b1;
    bus.m_avalid[r] = 1'b1;
    bus.m_addr[r*AW +: AW] = a;
    bus.m_len[r*LW +: LW]  = LW'(len);
    #1;
    chk("idle_gnt", 64'(gnt), 64'd0);
    chk("idle_aready", 64'(bus.m_aready), 64'd0);
    tick();
    chk("addr_gnt", 64'(gnt), 64'(1 << r));
    chk("addr_svalid", 64'(bus.s_avalid), 64'd1);
    chk("addr_saddr", 64'(bus.s_addr), 64'(a));
    chk("addr_slen", 64'(bus.s_len), 64'(len));
    chk("addr_aready", 64'(bus.m_aready), 64'(1 << r));
    chk("addr_nodata", 64'(bus.s_valid), 64'd0);
    tick();
    bus.m_avalid[r] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.m_valid[r] = 1'b1;
      bus.m_data[r*DW +: DW] = base + 64'(b);
      bus.m_last[r] = (b == len);
      #1;
      chk("beat_svalid", 64'(bus.s_valid), 64'd1);
      chk("beat_sdata", bus.s_data, base + 64'(b));
      chk("beat_slast", 64'(bus.s_last), 64'(b == len));
      chk("beat_mready", 64'(bus.m_ready), 64'(1 << r));
      chk("beat_err", 64'(err), 64'd0);
      tick();
    end
    bus.m_valid[r] = 1'b0;
    bus.m_last[r]  = 1'b0;
    #1;
    chk("end_gnt", 64'(gnt), 64'd0);
    chk("end_svalid", 64'(bus.s_valid), 64'd0);
    chk("end_err", 64'(err), 64'd0);
  endtask

  initial begin
    int ord[5];
    int rs[4];
    int b;
    ord = '{0, 1, 2, 3, 0};
    rs  = '{1, 0, 0, 1};

    clr();
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_svalid", 64'(bus.s_avalid), 64'd0);
    chk("rst_aready", 64'(bus.m_aready), 64'd0);
    chk("rst_slast", 64'(bus.s_last), 64'd0);
    #10;
    rst = 1'b1;
    tick();

    // single burst, len=3
    burst(0, 32'h100, 3, 64'hD0);

    // same-cycle requests from fresh round-robin pointer
    clr();
    pulse_reset();
    tick();
    bus.s_aready = 1'b1;
    bus.s_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.m_avalid[i] = 1'b1;
      bus.m_valid[i]  = 1'b1;
      bus.m_last[i]   = 1'b1;
      bus.m_data[i*DW +: DW] = 64'hA0 + 64'(i);
    end
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("rr_idle", 64'(gnt), 64'd0);
      chk("rr_err", 64'(err), 64'd0);
      tick();
      chk("rr_gnt", 64'(gnt), 64'(1 << ord[j]));
      tick();
      chk("rr_data", bus.s_data, 64'hA0 + 64'(ord[j]));
      chk("rr_last", 64'(bus.s_last), 64'd1);
      chk("rr_mready", 64'(bus.m_ready), 64'(1 << ord[j]));
      tick();
    end
    clr();
    #1;
    chk("rr_done", 64'(gnt), 64'd0);

    // backpressure on data
    tick();
    bus.s_aready = 1'b1;
    bus.m_avalid[2] = 1'b1;
    bus.m_addr[2*AW +: AW] = 32'h200;
    bus.m_len[2*LW +: LW]  = 8'd1;
    tick();
    chk("bp_gnt", 64'(gnt), 64'd4);
    tick();
    bus.m_avalid[2] = 1'b0;
    b = 0;
    for (int j = 0; j < 4; j++) begin
      bus.s_ready    = rs[j][0];
      bus.m_valid[2] = 1'b1;
      bus.m_data[2*DW +: DW] = 64'h300 + 64'(b);
      bus.m_last[2]  = (b == 1);
      #1;
      chk("bp_mready", 64'(bus.m_ready), (rs[j] != 0) ? 64'd4 : 64'd0);
      chk("bp_sdata", bus.s_data, 64'h300 + 64'(b));
      chk("bp_slast", 64'(bus.s_last), 64'(b == 1));
      tick();
      if (rs[j] != 0) b++;
    end
    #1;
    chk("bp_end", 64'(gnt), 64'd0);
    clr();

    // m_last early on beat 1 -> err after beats 1 and 2
    tick();
    bus.s_aready = 1'b1;
    bus.s_ready  = 1'b1;
    bus.m_avalid[1] = 1'b1;
    bus.m_addr[1*AW +: AW] = 32'h400;
    bus.m_len[1*LW +: LW]  = 8'd2;
    tick();
    chk("ml_gnt", 64'(gnt), 64'd2);
    tick();
    bus.m_avalid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.m_valid[1] = 1'b1;
      bus.m_data[1*DW +: DW] = 64'h500 + 64'(k);
      bus.m_last[1]  = (k == 1);
      #1;
      chk("ml_err", 64'(err), 64'(k == 2));
      chk("ml_slast", 64'(bus.s_last), 64'(k == 2));
      chk("ml_sdata", bus.s_data, 64'h500 + 64'(k));
      tick();
    end
    #1;
    chk("ml_err_last", 64'(err), 64'd1);
    chk("ml_gnt_end", 64'(gnt), 64'd0);
    tick();
    chk("ml_err_clear", 64'(err), 64'd0);
    clr();

    // async reset mid-DATA at cnt=5
    bus.s_aready = 1'b1;
    bus.s_ready  = 1'b1;
    bus.m_avalid[0] = 1'b1;
    bus.m_len[0*LW +: LW] = 8'd7;
    tick();
    tick();
    bus.m_avalid[0] = 1'b0;
    bus.m_valid[0]  = 1'b1;
    bus.m_data[0*DW +: DW] = 64'hBEEF;
    tick();
    tick();
    chk("ar_pre_valid", 64'(bus.s_valid), 64'd1);
    chk("ar_pre_last", 64'(bus.s_last), 64'd0);
    rst = 1'b0;
    #1;
    chk("ar_gnt", 64'(gnt), 64'd0);
    chk("ar_svalid", 64'(bus.s_valid), 64'd0);
    chk("ar_mready", 64'(bus.m_ready), 64'd0);
    chk("ar_sdata", bus.s_data, 64'd0);
    chk("ar_err", 64'(err), 64'd0);
    clr();
    #1;
    rst = 1'b1;
    burst(3, 32'h3000, 1, 64'h600);

    // maximum length burst: 256 beats
    tick();
    burst(1, 32'h4000, 255, 64'h7000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
